irq_request_arbiter: RTL and testbench
======================================

// Module: irq_request_arbiter
// PURPOSE
//   Upstream stage of the priority-encoding path. Captures rising edges on N request lines
//   into sticky pending bits and applies a mask. Presents the highest-priority pending ID
//   over a valid/ready handshake, and clears the pending bit when the consumer accepts it.
//   Feeds interrupt-style consumers that need a stable, held request ID.
// PARAMETERS
//   N_REQ  4  number of request lines (power of two, 2..16)
//   ID_W   2  width of irq_id; must equal $clog2(N_REQ)
// PORTS
//   clk          in   1      rising-edge clock; single clock domain
//   rst          in   1      asynchronous, active-high reset
//   req          in   N_REQ  raw request lines, level; a 0->1 transition registers a request
//   mask         in   N_REQ  1 = line masked (stays pending, never offered)
//   en           in   1      1 = block may start a new offer
//   irq_valid    out  1      offer valid
//   irq_id       out  ID_W   offered line index; stable while irq_valid=1
//   irq_ready    in   1      consumer accepts when irq_valid & irq_ready at a rising edge
//   pending      out  N_REQ  registered pending vector
//   any_pending  out  1      |pending, registered
// BEHAVIOUR
//   - Reset (async assert, sync release) drives all of the following to 0 and the FSM to IDLE:
//     pending, any_pending, irq_valid, irq_id, req_d. An offer in flight is dropped at once.
//   - Edge detect: rise = req_s & ~req_d, where req_d is req_s registered.
//     req_s = req, or the synchronised req when IRQ_SYNC_EN is defined.
//   - Pending update, every edge: pending <= (pending & ~clr) | rise.
//     clr is one-hot(irq_id) on acceptance, else 0.
//     Set wins: a rise on the line being cleared in the same cycle leaves its bit at 1.
//   - Eligibility: elig = pending & ~mask. Priority is fixed; the highest index wins (bit N_REQ-1 first).
//   - FSM IDLE -> OFFER: taken when en=1 and elig!=0.
//     Registers irq_id = highest set bit of elig and sets irq_valid=1 on that edge.
//   - FSM OFFER -> IDLE: taken on irq_ready=1 at an edge. Clears pending[irq_id] and sets irq_valid=0.
//     This gives one bubble cycle minimum between offers.
//   - In OFFER the offer is never retracted or changed, even if any of these happen:
//     mask[irq_id] goes to 1, en goes to 0, or a higher-priority request arrives.
//   - irq_ready while in IDLE is ignored.
//   - Latency without sync: req rises before edge t -> pending bit set at edge t -> irq_valid=1 at edge t+1.
//     This holds when the FSM is in IDLE, en=1 and the line is the highest eligible.
//   - A line held high does not re-trigger; it must fall and rise again.
//     Repeat rises while already pending collapse into one request.
//   - If elig=0 or en=0 while in IDLE, the FSM stays in IDLE with irq_valid=0. irq_id holds its last value.
// CONFIGURATION
//   IRQ_SYNC_EN defined:
//     - req passes through a 2-flop synchroniser per bit; those flops reset to 0.
//     - Edge-to-pending latency grows by 2 cycles; req may then be asynchronous to clk.
//   IRQ_SYNC_EN undefined:
//     - req is used directly and must be synchronous to clk.
//     - No extra flops; latency is as stated in BEHAVIOUR.
// STRUCTURE
//   - Package irq_pkg:
//     - N_REQ_DEF=4 and ID_W_DEF=2.
//     - typedef enum logic {IDLE, OFFER} arb_state_t.
//     - Function onehot(id) returns logic [N_REQ-1:0].
//   - Sub-module prio_enc_n #(N_REQ, ID_W):
//     - Combinational, highest-index-wins.
//     - Inputs vec; outputs idx and found.
//     - Instantiated once, on elig.
//   - The top level holds the synchroniser, edge detector, pending register and FSM.
// TESTING
//   1 Reset: assert rst mid-offer (irq_valid=1, irq_id=2).
//     -> irq_valid, pending, irq_id all 0 immediately, before the next clk edge.
//   2 Single request: mask=0, en=1, pulse req=4'b0010.
//     -> pending=0010 at t, irq_valid=1 with irq_id=1 at t+1.
//     -> After irq_ready: pending=0000, irq_valid=0.
//   3 Priority: raise req=4'b1011 in one cycle, irq_ready held 1.
//     -> Offers come out as IDs 3, 1, 0, each separated by one idle cycle.
//   4 Mask: mask=4'b1000, req=4'b1001.
//     -> Only ID 0 is offered and pending[3] stays 1.
//     -> Clearing mask afterwards produces an offer of ID 3.
//   5 Hold: offer ID 1 with irq_ready=0 for 5 cycles; during that time raise req[3] and drop en.
//     -> irq_id stays 1 throughout and irq_valid stays 1.
//   6 Set-wins: req[2] rises in the same cycle as the acceptance of ID 2.
//     -> pending[2]=1 afterwards, and ID 2 is offered again.
//     -> Rerun with IRQ_SYNC_EN defined: every latency is +2 cycles.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt request arbiter.
package irq_pkg;

   localparam int unsigned N_REQ_DEF = 4;
   localparam int unsigned ID_W_DEF  = 2;
   localparam int unsigned MAX_REQ   = 16;
   localparam int unsigned MAX_ID_W  = 4;

   typedef enum logic {IDLE, OFFER} arb_state_t;

   // Sized for the largest supported N_REQ; callers cast down to their own width.
   function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_ID_W-1:0] id);
      logic [MAX_REQ-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/irq_request_arbiter_if.sv
// Valid/ready offer channel carrying the selected request ID.
interface irq_request_arbiter_if
   import irq_pkg::*;
#(
   parameter int unsigned ID_W = ID_W_DEF
);
   logic            irq_valid;
   logic [ID_W-1:0] irq_id;
   logic            irq_ready;

   modport master (output irq_valid, output irq_id, input irq_ready);
   modport slave  (input irq_valid, input irq_id, output irq_ready);
endinterface

// File: rtl/prio_enc_n.sv
// Combinational priority encoder; the highest set index wins.
module prio_enc_n #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_REQ-1:0] vec,
   output logic [ID_W-1:0]  idx,
   output logic             found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      // Ascending scan so later (higher) hits overwrite earlier ones.
      for (int i = 0; i < N_REQ; i++) begin
         if (vec[i]) begin
            idx   = ID_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_request_arbiter.sv
// Edge-captured, maskable request arbiter with a held valid/ready offer.
// Define IRQ_SYNC_EN to pass req through a 2-flop synchroniser per bit.
module irq_request_arbiter
   import irq_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned ID_W  = ID_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ-1:0]      mask,
   input  logic                  en,
   irq_request_arbiter_if.master irq,
   output logic [N_REQ-1:0]      pending,
   output logic                  any_pending
);

   logic [N_REQ-1:0] req_s;
   logic [N_REQ-1:0] req_d;
   logic [N_REQ-1:0] rise;
   logic [N_REQ-1:0] clr;
   logic [N_REQ-1:0] pending_d;
   logic [N_REQ-1:0] elig;
   logic [ID_W-1:0]  top_idx;
   logic             top_found;
   logic             accept;
   arb_state_t       state;

`ifdef IRQ_SYNC_EN
   logic [N_REQ-1:0] sync1;
   logic [N_REQ-1:0] sync2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= req;
         sync2 <= sync1;
      end
   end

   assign req_s = sync2;
`else
   assign req_s = req;
`endif

   assign rise   = req_s & ~req_d;
   assign accept = (state == OFFER) && irq.irq_ready;
   assign clr    = accept ? N_REQ'(onehot(MAX_ID_W'(irq.irq_id))) : '0;
   // OR-ing rise last lets a new edge survive a same-cycle clear.
   assign pending_d = (pending & ~clr) | rise;
   assign elig      = pending & ~mask;

   prio_enc_n #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_prio_enc (
      .vec   (elig),
      .idx   (top_idx),
      .found (top_found)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_d       <= '0;
         pending     <= '0;
         any_pending <= 1'b0;
      end else begin
         req_d       <= req_s;
         pending     <= pending_d;
         any_pending <= |pending_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         irq.irq_valid <= 1'b0;
         irq.irq_id    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (en && top_found) begin
                  state         <= OFFER;
                  irq.irq_valid <= 1'b1;
                  irq.irq_id    <= top_idx;
               end
            end
            OFFER: begin
               // The offer is frozen until accepted, regardless of mask/en/new requests.
               if (irq.irq_ready) begin
                  state         <= IDLE;
                  irq.irq_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_request_arbiter.sv
// Randomized and directed bench for irq_request_arbiter against a cycle-level reference model.
module tb_irq_request_arbiter;

   localparam int N = 4;

   logic         clk;
   logic         rst;
   logic [N-1:0] req;
   logic [N-1:0] mask;
   logic         en;
   logic [N-1:0] pending;
   logic         any_pending;

   irq_request_arbiter_if #(.ID_W(2)) irq_bus ();

   irq_request_arbiter #(
      .N_REQ (N),
      .ID_W  (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .mask        (mask),
      .en          (en),
      .irq         (irq_bus.master),
      .pending     (pending),
      .any_pending (any_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tot = 0;
   int bad = 0;

   // Reference model state
   bit [N-1:0] m_pend;
   bit [N-1:0] m_prev;
   bit [N-1:0] m_s1;
   bit [N-1:0] m_s2;
   bit         m_valid;
   int         m_id;
   int         acc_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tot++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend  = '0;
      m_prev  = '0;
      m_s1    = '0;
      m_s2    = '0;
      m_valid = 1'b0;
      m_id    = 0;
   endtask

   // Effect of one rising edge given the inputs applied before it.
   task automatic model_step(input bit [N-1:0] r, input bit [N-1:0] mk, input bit e,
                             input bit rd);
      bit [N-1:0] rs;
      bit [N-1:0] nb;
      bit         acc;
`ifdef IRQ_SYNC_EN
      rs   = m_s2;
      m_s2 = m_s1;
      m_s1 = r;
`else
      rs = r;
`endif
      acc = m_valid && rd;
      for (int i = 0; i < N; i++)
         nb[i] = (m_pend[i] && !(acc && i == m_id)) || (rs[i] && !m_prev[i]);
      if (m_valid) begin
         if (rd) m_valid = 1'b0;
      end else if (e) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (m_pend[i] && !mk[i]) begin
               m_valid = 1'b1;
               m_id    = i;
               break;
            end
         end
      end
      m_prev = rs;
      m_pend = nb;
   endtask

   task automatic cycle(input bit [N-1:0] r, input bit [N-1:0] mk, input bit e, input bit rd);
      @(negedge clk);
      check("valid", 32'(irq_bus.irq_valid), 32'(m_valid));
      check("id", 32'(irq_bus.irq_id), 32'(m_id));
      check("pending", 32'(pending), 32'(m_pend));
      check("any_pending", 32'(any_pending), 32'(|m_pend));
      if (irq_bus.irq_valid && rd) acc_q.push_back(int'(irq_bus.irq_id));
      req               = r;
      mask              = mk;
      en                = e;
      irq_bus.irq_ready = rd;
      model_step(r, mk, e, rd);
   endtask

   task automatic wait_valid(input string tag, input bit [N-1:0] r, input bit e);
      for (int k = 0; k < 10; k++) begin
         if (irq_bus.irq_valid) break;
         cycle(r, '0, e, 1'b0);
      end
      check(tag, 32'(irq_bus.irq_valid), 32'd1);
   endtask

   // Called with rst high; releases it on a falling edge with idle inputs.
   task automatic release_reset();
      model_reset();
      @(negedge clk);
      req               = '0;
      mask              = '0;
      en                = 1'b0;
      irq_bus.irq_ready = 1'b0;
      rst               = 1'b0;
      model_step('0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst               = 1'b1;
      req               = '0;
      mask              = '0;
      en                = 1'b0;
      irq_bus.irq_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(irq_bus.irq_valid), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_id", 32'(irq_bus.irq_id), 32'd0);
      release_reset();

      // Single request on line 1
      cycle(4'b0010, '0, 1'b1, 1'b0);
      cycle(4'b0000, '0, 1'b1, 1'b0);
`ifndef IRQ_SYNC_EN
      check("single_pend", 32'(pending), 32'b0010);
      check("single_idle", 32'(irq_bus.irq_valid), 32'd0);
      cycle(4'b0000, '0, 1'b1, 1'b0);
      check("single_valid", 32'(irq_bus.irq_valid), 32'd1);
      check("single_id", 32'(irq_bus.irq_id), 32'd1);
`endif
      wait_valid("single_wait", '0, 1'b1);
      cycle('0, '0, 1'b1, 1'b1);
      cycle('0, '0, 1'b1, 1'b0);
      check("single_clr", 32'(pending), 32'd0);
      check("single_done", 32'(irq_bus.irq_valid), 32'd0);

      // Priority order with ready held high
      acc_q.delete();
      cycle(4'b1011, '0, 1'b1, 1'b1);
      repeat (12) cycle('0, '0, 1'b1, 1'b1);
      check("prio_cnt", 32'(acc_q.size()), 32'd3);
      if (acc_q.size() == 3) begin
         check("prio_0", 32'(acc_q[0]), 32'd3);
         check("prio_1", 32'(acc_q[1]), 32'd1);
         check("prio_2", 32'(acc_q[2]), 32'd0);
      end

      // Masked line stays pending and is offered only after unmasking
      acc_q.delete();
      cycle(4'b1001, 4'b1000, 1'b1, 1'b1);
      repeat (10) cycle('0, 4'b1000, 1'b1, 1'b1);
      check("mask_cnt", 32'(acc_q.size()), 32'd1);
      if (acc_q.size() == 1) check("mask_id", 32'(acc_q[0]), 32'd0);
      check("mask_pend", 32'(pending), 32'b1000);
      acc_q.delete();
      repeat (6) cycle('0, '0, 1'b1, 1'b1);
      check("unmask_cnt", 32'(acc_q.size()), 32'd1);
      if (acc_q.size() == 1) check("unmask_id", 32'(acc_q[0]), 32'd3);

      // Offer held while a higher request arrives and en drops
      cycle(4'b0010, '0, 1'b1, 1'b0);
      wait_valid("hold_wait", '0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         cycle(4'b1000, '0, 1'b0, 1'b0);
         check("hold_id", 32'(irq_bus.irq_id), 32'd1);
         check("hold_valid", 32'(irq_bus.irq_valid), 32'd1);
      end
      repeat (10) cycle('0, '0, 1'b1, 1'b1);

      // Set wins over a same-cycle clear
      cycle(4'b0100, '0, 1'b1, 1'b0);
      wait_valid("setw_wait", '0, 1'b1);
      check("setw_id", 32'(irq_bus.irq_id), 32'd2);
      cycle(4'b0000, '0, 1'b1, 1'b0);
`ifdef IRQ_SYNC_EN
      cycle(4'b0100, '0, 1'b1, 1'b0);
      cycle(4'b0100, '0, 1'b1, 1'b0);
`endif
      cycle(4'b0100, '0, 1'b1, 1'b1);
      cycle(4'b0100, '0, 1'b1, 1'b0);
      check("setw_pend", 32'(pending[2]), 32'd1);
      wait_valid("setw_reoffer", 4'b0100, 1'b1);
      check("setw_id2", 32'(irq_bus.irq_id), 32'd2);
      repeat (4) cycle('0, '0, 1'b1, 1'b1);

      // Async reset in the middle of an offer of ID 2
      cycle(4'b0100, '0, 1'b1, 1'b0);
      wait_valid("rst_wait", '0, 1'b1);
      check("rst_pre_id", 32'(irq_bus.irq_id), 32'd2);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(irq_bus.irq_valid), 32'd0);
      check("arst_pending", 32'(pending), 32'd0);
      check("arst_id", 32'(irq_bus.irq_id), 32'd0);
      check("arst_any", 32'(any_pending), 32'd0);
      release_reset();

      // Randomized traffic
      for (int k = 0; k < 500; k++) begin
         bit [N-1:0] r;
         bit [N-1:0] mk;
         r = req;
         for (int b = 0; b < N; b++) if ($urandom_range(0, 99) < 30) r[b] = ~r[b];
         mk = '0;
         for (int b = 0; b < N; b++) mk[b] = ($urandom_range(0, 99) < 20);
         cycle(r, mk, $urandom_range(0, 99) < 80, $urandom_range(0, 1) == 1);
      end
      cycle('0, '0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
